warp_laneskid: RTL and testbench

//   Multi-lane skid buffer: parametrised successor of the single-entry skid

---
 rtl/warp_laneskid.sv | 115 +++++++++++
 tb/tb_warp_laneskid.sv | 133 +++++++++++++
 2 files changed

// File: rtl/warp_laneskid.sv
// Multi-lane skid buffer: accepts up to LANES entries per cycle into a circular
// store and presents up to LANES oldest entries, all handshake outputs registered.
module warp_laneskid #(
    parameter  int WIDTH = 32,
    parameter  int LANES = 2,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(LANES + 1),
    localparam int OW    = $clog2(DEPTH + 1)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [CW-1:0]          i_wcount,
    input  logic [LANES*WIDTH-1:0] i_wdata,
    output logic [CW-1:0]          o_wcapacity,
    output logic [CW-1:0]          o_rcount,
    output logic [LANES*WIDTH-1:0] o_rdata,
    input  logic [CW-1:0]          i_rconsume,
    output logic [OW-1:0]          o_occupancy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    generate
        if (DEPTH < LANES) begin : g_bad_depth
            $error("warp_laneskid: DEPTH must be >= LANES");
        end
    endgenerate

    logic [WIDTH-1:0]       mem [DEPTH];
    logic [WIDTH-1:0]       mem_view [DEPTH];
    logic [PW-1:0]          head, tail, head_next, tail_next;
    logic [OW-1:0]          occ, occ_next;
    logic [CW-1:0]          accepted, consumed, rcount_next, wcap_next;
    logic [PW-1:0]          waddr [LANES];
    logic [LANES*WIDTH-1:0] rdata_next;

    // Pointer advance with explicit wrap; n never exceeds DEPTH, so one subtract suffices.
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int n);
        int s;
        s = int'(p) + n;
        if (s >= DEPTH) s = s - DEPTH;
        return PW'(s);
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    always_comb begin
        accepted    = CW'(imin(int'(i_wcount), int'(o_wcapacity)));
        consumed    = CW'(imin(int'(i_rconsume), int'(o_rcount)));
        occ_next    = OW'(int'(occ) + int'(accepted) - int'(consumed));
        head_next   = ptr_add(head, int'(consumed));
        tail_next   = ptr_add(tail, int'(accepted));
        rcount_next = CW'(imin(LANES, int'(occ_next)));
        wcap_next   = CW'(imin(LANES, DEPTH - int'(occ_next)));

        // Contents as they will be after this edge, so o_rdata can be registered
        // without a bypass path from i_wdata.
        for (int d = 0; d < DEPTH; d++) mem_view[d] = mem[d];
        for (int k = 0; k < LANES; k++) begin
            waddr[k] = ptr_add(tail, k);
            if (k < int'(accepted)) mem_view[waddr[k]] = i_wdata[k*WIDTH +: WIDTH];
        end

        rdata_next = '0;
        for (int k = 0; k < LANES; k++) begin
            if (k < int'(rcount_next))
                rdata_next[k*WIDTH +: WIDTH] = mem_view[ptr_add(head_next, k)];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            head        <= '0;
            tail        <= '0;
            occ         <= '0;
            o_rcount    <= '0;
            o_wcapacity <= CW'(LANES);
            o_rdata     <= '0;
        end else begin
            head        <= head_next;
            tail        <= tail_next;
            occ         <= occ_next;
            o_rcount    <= rcount_next;
            o_wcapacity <= wcap_next;
            o_rdata     <= rdata_next;
        end
    end

    // NOTE: storage is deliberately not reset; stale words are never visible
    // because o_rdata lanes at or beyond o_rcount are forced to zero.
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            for (int k = 0; k < LANES; k++) begin
                if (k < int'(accepted)) mem[waddr[k]] <= i_wdata[k*WIDTH +: WIDTH];
            end
        end
    end

    assign o_occupancy = occ;

`ifdef WARP_FORMAL
    always_comb begin
        if (i_rst_n) begin
            assert (int'(occ) <= DEPTH);
            assert (int'(head) < DEPTH && int'(tail) < DEPTH);
            assert (int'(o_rcount) == imin(LANES, int'(occ)));
            assert (int'(o_wcapacity) == imin(LANES, DEPTH - int'(occ)));
            assert (((int'(tail) - int'(head) + DEPTH) % DEPTH) == (int'(occ) % DEPTH));
        end
    end
`endif

endmodule

// File: tb/tb_warp_laneskid.sv
// Randomised and directed bench for warp_laneskid (LANES=2, DEPTH=4, WIDTH=8)
// against a queue-based FIFO reference model.
module tb_warp_laneskid;

    localparam int WIDTH = 8;
    localparam int LANES = 2;
    localparam int DEPTH = 4;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [1:0]  i_wcount;
    logic [15:0] i_wdata;
    logic [1:0]  o_wcapacity;
    logic [1:0]  o_rcount;
    logic [15:0] o_rdata;
    logic [1:0]  i_rconsume;
    logic [2:0]  o_occupancy;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] q[$];

    warp_laneskid #(.WIDTH(WIDTH), .LANES(LANES), .DEPTH(DEPTH)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_wcount    (i_wcount),
        .i_wdata     (i_wdata),
        .o_wcapacity (o_wcapacity),
        .o_rcount    (o_rcount),
        .o_rdata     (o_rdata),
        .i_rconsume  (i_rconsume),
        .o_occupancy (o_occupancy)
    );

    always #5 i_clk = ~i_clk;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected outputs follow directly from the queue contents.
    task automatic check_model(input string tag);
        logic [15:0] exp_rdata;
        int n;
        n = imin(LANES, q.size());
        exp_rdata = '0;
        for (int k = 0; k < n; k++) exp_rdata[k*8 +: 8] = q[k];
        check({tag, "_occ"},   32'(o_occupancy), 32'(q.size()));
        check({tag, "_rcnt"},  32'(o_rcount),    32'(n));
        check({tag, "_cap"},   32'(o_wcapacity), 32'(imin(LANES, DEPTH - q.size())));
        check({tag, "_rdata"}, 32'(o_rdata),     32'(exp_rdata));
    endtask

    task automatic step(input string tag, input int wc, input logic [15:0] wd, input int rc);
        int acc, cons;
        i_wcount   = 2'(wc);
        i_wdata    = wd;
        i_rconsume = 2'(rc);
        acc  = imin(wc, imin(LANES, DEPTH - q.size()));
        cons = imin(rc, imin(LANES, q.size()));
        @(posedge i_clk);
        #1;
        repeat (cons) void'(q.pop_front());
        for (int k = 0; k < acc; k++) q.push_back(wd[k*8 +: 8]);
        check_model(tag);
    endtask

    task automatic do_reset(input string tag);
        i_rst_n    = 1'b0;
        i_wcount   = 2'($urandom_range(0, 3));
        i_wdata    = 16'($urandom);
        i_rconsume = 2'($urandom_range(0, 3));
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        q.delete();
        check_model(tag);
    endtask

    initial begin
        i_rst_n    = 1'b0;
        i_wcount   = '0;
        i_wdata    = '0;
        i_rconsume = '0;

        do_reset("reset");
        check("reset_rdata_const", 32'(o_rdata), 32'h0000);
        check("reset_cap_const", 32'(o_wcapacity), 32'd2);

        step("wr_a", 2, 16'hA1A0, 0);
        check("wr_a_rdata_const", 32'(o_rdata), 32'hA1A0);
        step("wr_b", 2, 16'hB1B0, 0);
        check("full_cap_const", 32'(o_wcapacity), 32'd0);
        step("full_offer", 2, 16'hEEDD, 0);
        check("full_occ_const", 32'(o_occupancy), 32'd4);
        check("full_rdata_const", 32'(o_rdata), 32'hA1A0);

        step("cons1", 0, 16'h0000, 1);
        step("partial", 2, 16'hC1C0, 1);
        check("partial_occ_const", 32'(o_occupancy), 32'd3);
        check("partial_rdata_const", 32'(o_rdata), 32'hB1B0);

        // Bring occupancy to 2, then stream at full rate with clamped over-consume.
        step("drain", 0, 16'h0000, 1);
        for (int i = 0; i < 10; i++) begin
            step("stream", 2, {8'(2*i+1), 8'(2*i)}, (i % 2 == 0) ? 3 : 2);
            check("stream_occ_const", 32'(o_occupancy), 32'd2);
        end

        step("to3", 1, 16'h0077, 0);
        check("pre_rst_occ", 32'(o_occupancy), 32'd3);
        do_reset("mid_reset");
        step("post_rst_wr", 1, 16'hAA5E, 0);
        check("post_rst_rdata_const", 32'(o_rdata), 32'h005E);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 3) do_reset("rnd_reset");
            else step("rnd", $urandom_range(0, 3), 16'($urandom), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
